// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and shared memory port signals
// that meet at the memory port arbiter.
//   slave  : arbiter view (takes requests, drives ok/rdata and the m_* bus)
//   master : environment view (issues requests, answers on m_ack/m_rdata)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   // fetch (instruction) requester
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ok;
   logic [DATA_W-1:0] i_rdata;
   // memory-stage (data) requester
   logic                  d_valid;
   logic                  d_write;
   logic [2:0]            d_size;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_strobe;
   logic                  d_ok;
   logic [DATA_W-1:0]     d_rdata;
   // shared downstream port
   logic                  m_valid;
   logic                  m_write;
   logic [2:0]            m_size;
   logic [ADDR_W-1:0]     m_addr;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W/8-1:0]   m_strobe;
   logic                  m_ack;
   logic [DATA_W-1:0]     m_rdata;

   modport slave (
      input  i_valid, i_addr,
      output i_ok, i_rdata,
      input  d_valid, d_write, d_size, d_addr, d_wdata, d_strobe,
      output d_ok, d_rdata,
      output m_valid, m_write, m_size, m_addr, m_wdata, m_strobe,
      input  m_ack, m_rdata
   );

   modport master (
      output i_valid, i_addr,
      input  i_ok, i_rdata,
      output d_valid, d_write, d_size, d_addr, d_wdata, d_strobe,
      input  d_ok, d_rdata,
      input  m_valid, m_write, m_size, m_addr, m_wdata, m_strobe,
      output m_ack, m_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the fetch stage and the memory stage.
// The winning request is latched into a request register and held on the
// m_* bus until m_ack; the response is steered back to the owner.
// Data requests win by default; after STARVE_LIMIT consecutive data grants
// with fetch waiting, fetch is granted next.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mem_port_arbiter_if.slave (requesters + shared port)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_port_arbiter_if.slave      bus
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t              state_q,      state_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                m_valid_q,    m_valid_d;
   logic                req_write_q,  req_write_d;
   logic [2:0]          req_size_q,   req_size_d;
   logic [ADDR_W-1:0]   req_addr_q,   req_addr_d;
   logic [DATA_W-1:0]   req_wdata_q,  req_wdata_d;
   logic [STRB_W-1:0]   req_strobe_q, req_strobe_d;

   logic starved;
   assign starved = (starve_cnt_q >= 4'(STARVE_LIMIT));

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      m_valid_d    = m_valid_q;
      req_write_d  = req_write_q;
      req_size_d   = req_size_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_strobe_d = req_strobe_q;
      unique case (state_q)
         IDLE: begin
            // starvation override first, then data priority, then fetch
            if ((starved && bus.i_valid) || (!bus.d_valid && bus.i_valid)) begin
               state_d      = GNT_I;
               m_valid_d    = 1'b1;
               starve_cnt_d = 4'd0;
               req_write_d  = 1'b0;
               req_size_d   = 3'b011;
               req_addr_d   = bus.i_addr;
               req_wdata_d  = '0;
               req_strobe_d = '0;
            end else if (bus.d_valid) begin
               state_d      = GNT_D;
               m_valid_d    = 1'b1;
               // only grants that actually lock fetch out count toward starvation
               if (bus.i_valid)
                  starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
               else
                  starve_cnt_d = 4'd0;
               req_write_d  = bus.d_write;
               req_size_d   = bus.d_size;
               req_addr_d   = bus.d_addr;
               req_wdata_d  = bus.d_wdata;
               req_strobe_d = bus.d_strobe;
            end
         end
         GNT_I, GNT_D: begin
            // the transaction runs to m_ack even if the owner flushed
            if (bus.m_ack) begin
               state_d   = IDLE;
               m_valid_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         m_valid_q    <= 1'b0;
         req_write_q  <= 1'b0;
         req_size_q   <= 3'd0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_strobe_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         m_valid_q    <= m_valid_d;
         req_write_q  <= req_write_d;
         req_size_q   <= req_size_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_strobe_q <= req_strobe_d;
      end
   end

   assign bus.m_valid  = m_valid_q;
   assign bus.m_write  = req_write_q;
   assign bus.m_size   = req_size_q;
   assign bus.m_addr   = req_addr_q;
   assign bus.m_wdata  = req_wdata_q;
   assign bus.m_strobe = req_strobe_q;

   // a flushed owner (valid dropped) gets no ok for its still-running access
   assign bus.i_ok    = (state_q == GNT_I) & bus.m_ack & bus.i_valid;
   assign bus.d_ok    = (state_q == GNT_D) & bus.m_ack & bus.d_valid;
   assign bus.i_rdata = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_if ();

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      bit          is_d;
      logic [63:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic [7:0]  strb;
      bit          flushed;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   ack_delay = 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(bit is_d, logic [63:0] addr, logic wr, logic [2:0] size,
                                   logic [63:0] wdata, logic [7:0] strb, bit flushed);
      exp_t e;
      e.is_d = is_d; e.addr = addr; e.wr = wr; e.size = size;
      e.wdata = wdata; e.strb = strb; e.flushed = flushed;
      return e;
   endfunction

   function automatic logic [63:0] rdata_of(logic [63:0] addr);
      if (addr == 64'h8000_0000) return 64'h1234;
      return addr ^ 64'hDEAD_BEEF_0000_0000;
   endfunction

   // memory responder: ack after ack_delay cycles of m_valid
   initial begin
      int cnt = 0;
      bus_if.m_ack = 1'b0;
      bus_if.m_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset || !bus_if.m_valid || bus_if.m_ack) begin
            cnt = 0;
            bus_if.m_ack = 1'b0;
         end else begin
            cnt++;
            if (cnt >= ack_delay) begin
               bus_if.m_ack = 1'b1;
               bus_if.m_rdata = rdata_of(bus_if.m_addr);
               cnt = 0;
            end
         end
      end
   end

   // scoreboard monitor: check fields at grant start, routing at ack
   initial begin
      bit   prev_mv = 0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_mv = 0;
            continue;
         end
         if (bus_if.m_valid && !prev_mv) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_grant", 64'd1, 64'd0);
            end else begin
               cur = exp_q[0];
               check_val("grant_addr",  bus_if.m_addr,   cur.addr);
               check_val("grant_write", 64'(bus_if.m_write),  64'(cur.wr));
               check_val("grant_size",  64'(bus_if.m_size),   64'(cur.size));
               check_val("grant_wdata", bus_if.m_wdata,  cur.wdata);
               check_val("grant_strobe", 64'(bus_if.m_strobe), 64'(cur.strb));
            end
         end
         if (bus_if.m_valid && bus_if.m_ack && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_val("ack_addr", bus_if.m_addr, cur.addr);
            check_val("i_ok_ack", 64'(bus_if.i_ok), 64'(!cur.is_d && !cur.flushed));
            check_val("d_ok_ack", 64'(bus_if.d_ok), 64'(cur.is_d && !cur.flushed));
            if (!cur.flushed) begin
               if (cur.is_d) check_val("d_rdata", bus_if.d_rdata, rdata_of(cur.addr));
               else          check_val("i_rdata", bus_if.i_rdata, rdata_of(cur.addr));
            end
            $display("txn %s addr=0x%0h wr=%0d flushed=%0d done at %0t",
                     cur.is_d ? "D" : "I", cur.addr, cur.wr, cur.flushed, $time);
         end else begin
            check_val("i_ok_quiet", 64'(bus_if.i_ok), 64'd0);
            check_val("d_ok_quiet", 64'(bus_if.d_ok), 64'd0);
         end
         prev_mv = bus_if.m_valid;
      end
   end

   // wait for the owner's ok, then drop its valid on the following edge
   task automatic wait_ok(input bit is_d, input string tag);
      int n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (is_d ? bus_if.d_ok : bus_if.i_ok) break;
         n++;
      end
      if (n >= 200) check_val(tag, 64'd0, 64'd1);
      @(posedge clk); #1;
      if (is_d) bus_if.d_valid = 1'b0;
      else      bus_if.i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus_if.i_valid = 0; bus_if.i_addr = '0;
      bus_if.d_valid = 0; bus_if.d_write = 0; bus_if.d_size = '0;
      bus_if.d_addr = '0; bus_if.d_wdata = '0; bus_if.d_strobe = '0;

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_m_valid", 64'(bus_if.m_valid), 64'd0);
      check_val("rst_i_ok",    64'(bus_if.i_ok),    64'd0);
      check_val("rst_d_ok",    64'(bus_if.d_ok),    64'd0);
      check_val("rst_m_addr",  bus_if.m_addr,       64'd0);
      check_val("rst_m_size",  64'(bus_if.m_size),  64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      // fetch alone
      ack_delay = 3;
      exp_q.push_back(mk_exp(0, 64'h8000_0000, 0, 3'b011, 64'd0, 8'd0, 0));
      bus_if.i_valid = 1; bus_if.i_addr = 64'h8000_0000;
      @(negedge clk); check_val("fetch_mv_n",  64'(bus_if.m_valid), 64'd0);
      @(negedge clk); check_val("fetch_mv_n1", 64'(bus_if.m_valid), 64'd1);
      wait_ok(0, "fetch_timeout");
      idle(2);

      // store alone, requester fields change mid-grant
      ack_delay = 4;
      exp_q.push_back(mk_exp(1, 64'h10, 1, 3'b000, 64'hFF, 8'h01, 0));
      bus_if.d_valid = 1; bus_if.d_write = 1; bus_if.d_size = 3'b000;
      bus_if.d_addr = 64'h10; bus_if.d_wdata = 64'hFF; bus_if.d_strobe = 8'h01;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      bus_if.d_addr = 64'h999; bus_if.d_wdata = 64'h0;
      @(negedge clk);
      check_val("store_addr_held",  bus_if.m_addr,  64'h10);
      check_val("store_wdata_held", bus_if.m_wdata, 64'hFF);
      wait_ok(1, "store_timeout");
      @(negedge clk);
      check_val("idle_m_valid", 64'(bus_if.m_valid), 64'd0);
      check_val("idle_m_addr_hold", bus_if.m_addr, 64'h10);
      idle(2);

      // contention: data first, then fetch
      ack_delay = 1;
      bus_if.d_write = 0; bus_if.d_size = 3'b011; bus_if.d_addr = 64'h20;
      bus_if.d_wdata = 0; bus_if.d_strobe = 0;
      exp_q.push_back(mk_exp(1, 64'h20, 0, 3'b011, 64'd0, 8'd0, 0));
      exp_q.push_back(mk_exp(0, 64'h100, 0, 3'b011, 64'd0, 8'd0, 0));
      bus_if.d_valid = 1; bus_if.i_valid = 1; bus_if.i_addr = 64'h100;
      wait_ok(1, "contend_d_timeout");
      wait_ok(0, "contend_i_timeout");
      idle(2);

      // starvation: four data grants, then fetch
      bus_if.d_addr = 64'h40; bus_if.i_addr = 64'h200;
      for (int k = 0; k < 4; k++)
         exp_q.push_back(mk_exp(1, 64'h40, 0, 3'b011, 64'd0, 8'd0, 0));
      exp_q.push_back(mk_exp(0, 64'h200, 0, 3'b011, 64'd0, 8'd0, 0));
      exp_q.push_back(mk_exp(1, 64'h40, 0, 3'b011, 64'd0, 8'd0, 0));
      bus_if.d_valid = 1; bus_if.i_valid = 1;
      begin
         int n = 0;
         while (n < 200) begin
            @(negedge clk);
            if (bus_if.i_ok) break;
            n++;
         end
         if (n >= 200) check_val("starve_timeout", 64'd0, 64'd1);
         check_val("starve_cnt_clear", 64'(dut.starve_cnt_q), 64'd0);
         @(posedge clk); #1;
         bus_if.i_valid = 0;
      end
      wait_ok(1, "starve_d_timeout");
      idle(2);
      check_val("starve_q_empty", 64'(exp_q.size()), 64'd0);

      // flush: data drops valid mid-grant
      ack_delay = 4;
      bus_if.d_addr = 64'h300;
      exp_q.push_back(mk_exp(1, 64'h300, 0, 3'b011, 64'd0, 8'd0, 1));
      bus_if.d_valid = 1;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      bus_if.d_valid = 0;
      @(negedge clk);
      check_val("flush_m_valid_held", 64'(bus_if.m_valid), 64'd1);
      begin
         int n = 0;
         while (n < 50 && bus_if.m_valid) begin
            @(negedge clk);
            n++;
         end
         check_val("flush_return_idle", 64'(bus_if.m_valid), 64'd0);
      end
      idle(2);

      // async reset in the middle of a fetch grant
      ack_delay = 10;
      bus_if.i_addr = 64'h400;
      exp_q.push_back(mk_exp(0, 64'h400, 0, 3'b011, 64'd0, 8'd0, 0));
      bus_if.i_valid = 1;
      @(negedge clk); @(negedge clk);
      check_val("pre_rst_m_valid", 64'(bus_if.m_valid), 64'd1);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check_val("async_rst_m_valid", 64'(bus_if.m_valid), 64'd0);
      check_val("async_rst_i_ok",    64'(bus_if.i_ok),    64'd0);
      check_val("async_rst_m_addr",  bus_if.m_addr,       64'd0);
      bus_if.i_valid = 0;
      idle(2);
      reset = 1'b1;
      idle(1);

      // normal data request after reset
      ack_delay = 2;
      bus_if.d_addr = 64'h500;
      exp_q.push_back(mk_exp(1, 64'h500, 0, 3'b011, 64'd0, 8'd0, 0));
      bus_if.d_valid = 1;
      wait_ok(1, "post_rst_timeout");
      idle(3);
      check_val("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the fetch stage (instruction requester) and the memory stage (data requester) of the pipeline. Sits between the two pipeline-side bus masters and the downstream memory interface. It latches the winning request, holds it on the shared port until acknowledged, and routes the response back to the owner. Data requests win by default, since the memory-stage instruction is older; a starvation counter bounds how long fetch can be locked out.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (strobe width = DATA_W/8)
- STARVE_LIMIT, 4, consecutive data grants after which a waiting instruction request gets priority (range 1..15)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- i_valid  in  1  fetch request pending; held high until i_ok
- i_addr  in  ADDR_W  fetch address
- i_ok  out  1  fetch response valid (one cycle)
- i_rdata  out  DATA_W  fetch read data, valid when i_ok
- d_valid  in  1  data request pending; held high until d_ok
- d_write  in  1  1 = store, 0 = load
- d_size  in  3  access size code, passed through
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_strobe  in  DATA_W/8  byte enables
- d_ok  out  1  data response valid (one cycle)
- d_rdata  out  DATA_W  load data, valid when d_ok
- m_valid  out  1  shared-port request valid
- m_write, m_size, m_addr, m_wdata, m_strobe  out  1/3/ADDR_W/DATA_W/DATA_W/8  latched request fields
- m_ack  in  1  downstream completion (one cycle); completes the current request
- m_rdata  in  DATA_W  downstream read data, valid with m_ack

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - starve_cnt >= STARVE_LIMIT and i_valid: go to GNT_I.
  - Otherwise d_valid: go to GNT_D.
  - Otherwise i_valid: go to GNT_I.
  - Otherwise stay in IDLE.
- On entering a grant state, the owner's request fields are captured into a request register. For an instruction request: write=0, size=3'b011, strobe=0, wdata=0.
- GNT_x: m_valid=1 and m_* come from the request register. Requester field changes during the grant are ignored. When m_ack=1, go to IDLE.
- Response routing is combinational:
  - i_ok = (state==GNT_I) & m_ack & i_valid
  - d_ok = (state==GNT_D) & m_ack & d_valid
  - i_rdata = d_rdata = m_rdata
- Owner drops valid mid-grant (flush): the downstream transaction still runs to m_ack, and its response is discarded (ok stays 0).
- starve_cnt (4 bits, saturating at 15) updates on each entry to a grant state:
  - Entering GNT_D while i_valid=1: increment.
  - Entering GNT_I: clear.
  - Entering GNT_D while i_valid=0: clear.
- IDLE: m_valid=0. m_* fields hold their last latched values.

## Timing
- Reset (asynchronous, while reset=0), effective immediately:
  - state=IDLE, starve_cnt=0, request register=0.
  - m_valid=0, i_ok=0, d_ok=0, all m_* outputs 0.
- Reset during a grant abandons the transaction; no ok is produced.
- Request sampled in IDLE at cycle N: m_valid=1 from cycle N+1.
- m_ack at cycle K: the owner's ok is asserted in cycle K. State is IDLE at K+1, and the earliest next m_valid is K+2.
- Minimum request-to-ok latency is 1 cycle plus memory latency. There is one idle turnaround cycle between grants.
- Simultaneous i_valid and d_valid in IDLE: data wins unless starve_cnt >= STARVE_LIMIT.
- m_ack while in IDLE is ignored.

## Test plan
- Fetch alone: i_valid=1, i_addr=0x8000_0000, m_ack after 3 cycles with m_rdata=0x1234 -> m_valid rises 1 cycle after i_valid, m_addr=0x8000_0000, m_write=0, i_ok=1 with i_rdata=0x1234 for exactly one cycle, d_ok=0.
- Store alone: d_valid=1, d_write=1, d_addr=0x10, d_wdata=0xFF, d_strobe=0x01 -> m_* carry these values. Changing d_addr mid-grant does not change m_addr. d_ok pulses with m_ack.
- Contention: i_valid and d_valid raised in the same cycle, m_ack always 1 cycle after m_valid -> data granted first. After d_ok, d_valid is dropped and the fetch is granted at the next IDLE.
- Starvation: i_valid held high, d_valid re-asserted immediately after each d_ok -> exactly 4 data grants (STARVE_LIMIT=4), then a GNT_I. starve_cnt=0 afterwards.
- Flush: in GNT_D, d_valid dropped before m_ack -> m_valid stays high until m_ack, d_ok=0, then return to IDLE.
- Async reset: reset=0 asserted mid-GNT_I between clock edges -> m_valid=0 and i_ok=0 immediately. After reset=1, a new request on d_valid is granted normally.
